// File: rtl/pipeline_flow_ctrl.sv
// pipeline_flow_ctrl: stall/flush/redirect control for a 5-stage pipeline with
// precise exceptions at M, eret handling and a saturating stall counter.
module pipeline_flow_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        hz_stall,
    input  logic        md_stall,
    input  logic        exc_M,
    input  logic        bd_M,
    input  logic [31:0] pc_M,
    input  logic        eret_M,
    input  logic        exl,
    output logic        en_F,
    output logic        en_D,
    output logic        en_E,
    output logic        en_M,
    output logic        flush_D,
    output logic        flush_E,
    output logic        flush_M,
    output logic        flush_W,
    output logic [1:0]  pc_sel,
    output logic        epc_we,
    output logic [31:0] epc_data,
    output logic        exl_set,
    output logic        exl_clr,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt
);
    typedef enum logic [1:0] {RUN = 2'b00, FLUSH = 2'b01} state_t;
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        run, flsh, exc, eret, stall;
    always_comb begin
        run      = state_q == RUN;
        flsh     = state_q == FLUSH;
        exc      = run & exc_M & ~exl;
        eret     = run & eret_M & ~exc;
        stall    = run & ~exc & ~eret_M & (hz_stall | md_stall);
        // Any state other than RUN (FLUSH or an unused code) returns to RUN.
        state_d  = (exc | eret) ? FLUSH : RUN;
        cnt_d    = (stall && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
        en_F     = reset & ~stall;
        en_D     = reset & ~stall;
        en_E     = reset;
        en_M     = reset;
        flush_D  = ~reset | exc | eret | flsh;
        flush_E  = ~reset | exc | eret | stall;
        flush_M  = ~reset | exc | eret;
        flush_W  = ~reset | exc;
        pc_sel   = ~reset ? 2'b00 : exc ? 2'b01 : eret ? 2'b10 : 2'b00;
        epc_we   = reset & exc;
        exl_set  = reset & exc;
        exl_clr  = reset & eret;
        epc_data = {pc_M[31:2], 2'b00} - (bd_M ? 32'd4 : 32'd0);
        state    = state_q;
        stall_cnt = cnt_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_pipeline_flow_ctrl.sv
// tb_pipeline_flow_ctrl: randomized and directed scoreboard bench for pipeline_flow_ctrl.
module tb_pipeline_flow_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0, hz_stall = 1'b0, md_stall = 1'b0, exc_M = 1'b0;
    logic        bd_M = 1'b0, eret_M = 1'b0, exl = 1'b0;
    logic [31:0] pc_M = '0;
    logic        en_F, en_D, en_E, en_M, flush_D, flush_E, flush_M, flush_W;
    logic [1:0]  pc_sel, state;
    logic        epc_we, exl_set, exl_clr;
    logic [31:0] epc_data;
    logic [15:0] stall_cnt;
    logic [62:0] act;
    logic [62:0] exp_q[$];
    string       tag_q[$];
    event        ev;
    int          vectors = 0, miscompares = 0;
    bit          m_flush = 1'b0;
    int          m_cnt = 0;

    always #5 clk = ~clk;

    pipeline_flow_ctrl dut (
        .clk(clk), .reset(reset), .hz_stall(hz_stall), .md_stall(md_stall),
        .exc_M(exc_M), .bd_M(bd_M), .pc_M(pc_M), .eret_M(eret_M), .exl(exl),
        .en_F(en_F), .en_D(en_D), .en_E(en_E), .en_M(en_M),
        .flush_D(flush_D), .flush_E(flush_E), .flush_M(flush_M), .flush_W(flush_W),
        .pc_sel(pc_sel), .epc_we(epc_we), .epc_data(epc_data),
        .exl_set(exl_set), .exl_clr(exl_clr), .state(state), .stall_cnt(stall_cnt)
    );

    assign act = {en_F, en_D, en_E, en_M, flush_D, flush_E, flush_M, flush_W,
                  pc_sel, epc_we, epc_data, exl_set, exl_clr, state, stall_cnt};

    // Reference: one cycle of redirect-recovery after any taken event, else priority
    // exception > eret > stall > idle, counter saturating at 65535.
    task automatic step(input string tag, input logic r, h, m, x, b,
                        input logic [31:0] p, input logic e, l);
        logic [3:0]  en, fl;
        logic [1:0]  ps, st;
        logic        we, set, clr, stl;
        logic [31:0] ed;
        logic [15:0] c;
        @(negedge clk);
        reset = r; hz_stall = h; md_stall = m; exc_M = x; bd_M = b; pc_M = p; eret_M = e; exl = l;
        ed = (p & 32'hFFFF_FFFC) - (b ? 32'd4 : 32'd0);
        en = 4'hF; fl = 4'h0; ps = 2'd0; we = 0; set = 0; clr = 0; st = 2'd0; stl = 0;
        if (!r) begin
            en = 4'h0; fl = 4'hF; m_flush = 0; m_cnt = 0;
        end else if (m_flush) begin
            fl = 4'b1000; st = 2'b01; m_flush = 0;
        end else if (x && !l) begin
            fl = 4'hF; ps = 2'b01; we = 1; set = 1; m_flush = 1;
        end else if (e) begin
            fl = 4'b1110; ps = 2'b10; clr = 1; m_flush = 1;
        end else if (h || m) begin
            en = 4'b0011; fl = 4'b0100; stl = 1;
        end
        c = 16'(m_cnt);
        exp_q.push_back({en, fl, ps, we, ed, set, clr, st, c});
        tag_q.push_back(tag);
        if (stl && m_cnt < 65535) m_cnt++;
        ->ev;
    endtask

    always begin
        logic [62:0] e;
        string t;
        @(ev);
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            vectors++;
            if (act !== e) begin
                miscompares++;
                $display("FAIL %s: got en=%b fl=%b pc_sel=%b we=%b epc=%h set=%b clr=%b st=%b cnt=%h, want en=%b fl=%b pc_sel=%b we=%b epc=%h set=%b clr=%b st=%b cnt=%h",
                         t, act[62:59], act[58:55], act[54:53], act[52], act[51:20], act[19], act[18], act[17:16], act[15:0],
                         e[62:59], e[58:55], e[54:53], e[52], e[51:20], e[19], e[18], e[17:16], e[15:0]);
            end
        end
    end

    initial begin
        step("reset", 0, 0, 0, 0, 0, 32'h0, 0, 0);
        step("reset_bd0", 0, 1, 0, 1, 1, 32'h0, 1, 0);
        step("idle", 1, 0, 0, 0, 0, 32'h1234, 0, 0);
        repeat (3) step("hz_stall", 1, 1, 0, 0, 0, 32'h0, 0, 0);
        step("stall_done", 1, 0, 0, 0, 0, 32'h0, 0, 0);
        step("exc_bd", 1, 0, 0, 1, 1, 32'h0000_3010, 0, 0);
        step("exc_flush", 1, 0, 0, 1, 0, 32'h0, 0, 0);
        step("exc_run", 1, 0, 0, 0, 0, 32'h0, 0, 0);
        step("exc_eret_md", 1, 0, 1, 1, 0, 32'h0000_3004, 1, 0);
        step("exc_eret_fl", 1, 0, 1, 0, 0, 32'h0, 0, 0);
        step("eret", 1, 0, 0, 0, 0, 32'h0, 1, 1);
        step("eret_fl_exc", 1, 1, 0, 1, 0, 32'h0000_2000, 0, 0);
        step("exc_exl1", 1, 0, 0, 1, 0, 32'h0000_2000, 0, 1);
        step("epc_wrap", 1, 0, 0, 1, 1, 32'h0000_0003, 0, 0);
        step("mid_flush_rst", 0, 0, 0, 0, 0, 32'h0, 0, 0);
        step("after_rst", 1, 0, 0, 0, 0, 32'h0, 0, 0);
        step("md_stall", 1, 0, 1, 0, 0, 32'h0, 0, 0);
        step("mid_stall_rst", 0, 0, 1, 0, 0, 32'h0, 0, 0);
        step("after_rst2", 1, 0, 0, 0, 0, 32'h0, 0, 0);
        repeat (3000)
            step("random", $urandom_range(0, 49) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, 1'($urandom),
                 $urandom, $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
        step("pre_sat", 1, 0, 0, 0, 0, 32'h0, 0, 0);
        repeat (65537) step("sat_stall", 1, 1, 1, 0, 0, 32'h0, 0, 0);
        step("sat_hold", 1, 0, 0, 0, 0, 32'h0, 0, 0);
        step("sat_exc", 1, 1, 0, 1, 0, 32'hFFFF_FFF8, 0, 0);
        step("rst_in_flush", 0, 0, 0, 0, 0, 32'h0, 0, 0);
        step("final_idle", 1, 0, 0, 0, 0, 32'h0, 0, 0);
        @(negedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
